// File: rtl/mmu_satp_flush_ctrl.sv
// mmu_satp_flush_ctrl: satp CSR holder with WARL mode legalisation and a
// req/ack sequencer that broadcasts TLB invalidations to N_TLB channels.
// Global flushes (satp mode change, or merged with an sfence) carry
// vaddr = 0 and asid = 0 alongside all_va = all_asid = 1.
module mmu_satp_flush_ctrl #(
  parameter int XLEN       = 64,
  parameter int ASID_WIDTH = 9,
  parameter int N_TLB      = 2,
  parameter bit SV48_EN    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            misa_mxl,
  input  logic                  csr_wr,
  input  logic [11:0]           csr_waddr,
  input  logic [11:0]           csr_raddr,
  input  logic [XLEN-1:0]       csr_wdata,
  output logic [XLEN-1:0]       csr_rdata,
  output logic [43:0]           satp_ppn,
  output logic [ASID_WIDTH-1:0] satp_asid,
  output logic [3:0]            satp_mode,
  input  logic                  sfence_valid,
  output logic                  sfence_ready,
  input  logic [XLEN-1:0]       sfence_vaddr,
  input  logic [ASID_WIDTH-1:0] sfence_asid,
  input  logic                  sfence_all_va,
  input  logic                  sfence_all_asid,
  output logic [N_TLB-1:0]      tlb_flush_req,
  input  logic [N_TLB-1:0]      tlb_flush_ack,
  output logic [XLEN-1:0]       tlb_flush_vaddr,
  output logic [ASID_WIDTH-1:0] tlb_flush_asid,
  output logic                  tlb_flush_all_va,
  output logic                  tlb_flush_all_asid,
  output logic                  flush_busy,
  output logic                  flush_done
);

  localparam logic [11:0] SATP_ADDR = 12'h180;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_e;

  state_e                  state_q;
  logic [3:0]              mode_q;
  logic [ASID_WIDTH-1:0]   asid_q;
  logic [43:0]             ppn_q;
  logic                    pend_q;
  logic                    done_q;
  logic [N_TLB-1:0]        req_q;
  logic [XLEN-1:0]         fl_vaddr_q;
  logic [ASID_WIDTH-1:0]   fl_asid_q;
  logic                    fl_all_va_q;
  logic                    fl_all_asid_q;

  logic                    view32;
  logic [63:0]             wd64;
  logic [3:0]              wr_mode;
  logic [15:0]             wr_asid_raw;
  logic [ASID_WIDTH-1:0]   wr_asid;
  logic [43:0]             wr_ppn;
  logic                    mode_legal;
  logic                    satp_wr;
  logic                    mode_chg;
  logic [15:0]             asid16;
  logic [63:0]             rdata64;
  logic [N_TLB-1:0]        req_d;

  assign view32 = (XLEN == 32) || (misa_mxl == 2'd1);

  // Decode a satp write in the current view and decide whether it is legal.
  always_comb begin
    wd64        = 64'(csr_wdata);
    wr_mode     = 4'd0;
    wr_asid_raw = 16'd0;
    wr_ppn      = 44'd0;
    mode_legal  = 1'b0;
    if (view32) begin
      wr_mode     = {3'b000, wd64[31]};
      wr_asid_raw = {7'd0, wd64[30:22]};
      wr_ppn      = {22'd0, wd64[21:0]};
      mode_legal  = 1'b1;
    end else begin
      wr_mode     = wd64[63:60];
      wr_asid_raw = wd64[59:44];
      wr_ppn      = wd64[43:0];
      mode_legal  = (wr_mode == 4'd0) || (wr_mode == 4'd8) ||
                    (SV48_EN && (wr_mode == 4'd9));
    end
    wr_asid  = wr_asid_raw[ASID_WIDTH-1:0];
    satp_wr  = csr_wr && (csr_waddr == SATP_ADDR) && mode_legal;
    mode_chg = satp_wr && (wr_mode != mode_q);
  end

  // Pack satp for reads; unimplemented ASID bits read as zero.
  always_comb begin
    asid16  = 16'(asid_q);
    rdata64 = 64'd0;
    if (csr_raddr == SATP_ADDR) begin
      if (view32) rdata64 = {32'd0, mode_q[0], asid16[8:0], ppn_q[21:0]};
      else        rdata64 = {mode_q, asid16, ppn_q};
    end
  end

  assign csr_rdata = rdata64[XLEN-1:0];
  assign req_d     = req_q & ~tlb_flush_ack;

  // satp register: legal writes land regardless of flush activity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= 4'd0;
      asid_q <= '0;
      ppn_q  <= 44'd0;
    end else if (satp_wr) begin
      mode_q <= wr_mode;
      asid_q <= wr_asid;
      ppn_q  <= wr_ppn;
    end
  end

  // Flush sequencer: broadcast, collect per-channel acks, pulse done, replay pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      req_q         <= '0;
      pend_q        <= 1'b0;
      done_q        <= 1'b0;
      fl_vaddr_q    <= '0;
      fl_asid_q     <= '0;
      fl_all_va_q   <= 1'b0;
      fl_all_asid_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (sfence_valid || mode_chg) begin
            state_q <= REQ;
            req_q   <= '1;
            if (mode_chg) begin
              fl_vaddr_q    <= '0;
              fl_asid_q     <= '0;
              fl_all_va_q   <= 1'b1;
              fl_all_asid_q <= 1'b1;
            end else begin
              fl_vaddr_q    <= sfence_vaddr;
              fl_asid_q     <= sfence_asid;
              fl_all_va_q   <= sfence_all_va;
              fl_all_asid_q <= sfence_all_asid;
            end
          end
        end
        REQ: begin
          req_q <= req_d;
          if (mode_chg) pend_q <= 1'b1;
          if (req_d == '0) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          if (pend_q || mode_chg) begin
            pend_q        <= 1'b0;
            state_q       <= REQ;
            req_q         <= '1;
            fl_vaddr_q    <= '0;
            fl_asid_q     <= '0;
            fl_all_va_q   <= 1'b1;
            fl_all_asid_q <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign satp_mode          = mode_q;
  assign satp_asid          = asid_q;
  assign satp_ppn           = ppn_q;
  assign sfence_ready       = (state_q == IDLE);
  assign flush_busy         = (state_q != IDLE);
  assign flush_done         = done_q;
  assign tlb_flush_req      = req_q;
  assign tlb_flush_vaddr    = fl_vaddr_q;
  assign tlb_flush_asid     = fl_asid_q;
  assign tlb_flush_all_va   = fl_all_va_q;
  assign tlb_flush_all_asid = fl_all_asid_q;

endmodule
